jt89_wrq: RTL and testbench

JT89_WRQ -- requirements
Module: jt89_wrq

---
 rtl/jt89_wrq.sv | 84 ++++++++
 tb/tb_jt89_wrq.sv | 77 +++++++
 2 files changed

// File: rtl/jt89_wrq.sv
// jt89_wrq: FIFO-buffered CPU write queue that replays bytes to the PSG as timed psg_wr_n pulses
module jt89_wrq #(
  parameter int AW       = 3,
  parameter int LOW_CYC  = 2,
  parameter int HIGH_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_din,
  input  logic          ovf_clr,
  output logic          psg_wr_n,
  output logic [7:0]    psg_din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW:0]   level_nxt;
  logic          wr_n_nxt, push, pop, drop;
  assign push = cpu_wr && !full;
  assign drop = cpu_wr && full;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_n_nxt  = psg_wr_n;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        wr_n_nxt  = 1'b0;
        cnt_nxt   = 4'(LOW_CYC - 1);
        state_nxt = LOW;
      end
      LOW: if (cnt == 4'd0) begin
        wr_n_nxt  = 1'b1;
        cnt_nxt   = 4'(HIGH_CYC - 1);
        state_nxt = HIGH;
      end else cnt_nxt = cnt - 4'd1;
      HIGH: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
      else if (!empty) begin
        pop       = 1'b1;
        wr_n_nxt  = 1'b0;
        cnt_nxt   = 4'(LOW_CYC - 1);
        state_nxt = LOW;
      end else state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= cpu_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      psg_wr_n <= 1'b1;
      psg_din  <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      psg_wr_n <= wr_n_nxt;
      if (pop) psg_din <= mem[rd_ptr];
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      level    <= level_nxt;
      full     <= level_nxt == (AW+1)'(DEPTH);
      empty    <= level_nxt == '0;
      ovf      <= drop || (ovf && !ovf_clr);
    end
  end
endmodule

// File: tb/tb_jt89_wrq.sv
// tb_jt89_wrq: directed and random stimulus checked against a queue-based pulse-schedule model
module tb_jt89_wrq;
  localparam int AW = 3, L = 2, H = 2, DEPTH = 1 << AW;
  logic clk = 0, rst = 1, cpu_wr = 0, ovf_clr = 0;
  logic [7:0] cpu_din = 0;
  logic psg_wr_n, full, empty, ovf;
  logic [7:0] psg_din;
  logic [AW:0] level;
  int tests = 0, fails = 0, cyc = 0, last_pop = -100;
  logic [7:0] q[$];
  logic [7:0] m_din = 0;
  logic m_ovf = 0;
  jt89_wrq #(.AW(AW), .LOW_CYC(L), .HIGH_CYC(H)) dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .ovf_clr(ovf_clr),
    .psg_wr_n(psg_wr_n), .psg_din(psg_din), .full(full), .empty(empty),
    .level(level), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic c, input logic r);
    cpu_wr = w; cpu_din = d; ovf_clr = c; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete(); last_pop = -100; m_din = 0; m_ovf = 0;
    end else begin
      bit pop, drop;
      pop  = q.size() > 0 && cyc >= last_pop + L + H;
      drop = w && q.size() == DEPTH;
      if (pop) begin m_din = q.pop_front(); last_pop = cyc; end
      if (w && !drop) q.push_back(d);
      m_ovf = drop ? 1'b1 : c ? 1'b0 : m_ovf;
    end
    #1;
    chk("wr_n", psg_wr_n, (cyc - last_pop < L) ? 0 : 1);
    chk("din", psg_din, m_din);
    chk("level", level, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("ovf", ovf, m_ovf);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  initial begin
    step(0, 0, 0, 1);
    step(1, 8'h55, 0, 1);
    step(1, 8'h9F, 0, 0);
    idle(8);
    step(1, 8'h80, 0, 0); step(1, 8'h0A, 0, 0); step(1, 8'h90, 0, 0);
    idle(16);
    for (int i = 0; i < 14; i++) step(1, 8'(8'h10 + i), 0, 0);
    idle(10);
    step(0, 0, 1, 0);
    idle(40);
    step(0, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + i), 0, 0);
    idle(2);
    step(1, 8'hEE, 1, 0);
    idle(3);
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0);
    step(0, 0, 0, 1);
    idle(10);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
